// File: rtl/apb_slave_mem.sv
// apb_slave_mem -- APB v3.0 completer backed by a word-addressed memory.
//
// Each access phase lasts WAIT_CYCLES+1 cycles. Misaligned or out-of-range
// accesses complete with PSLVERR=1, never modify memory, and read as 0.
// xfer_done pulses for one cycle after every completed transfer.
//
// Ports:
//   PCLK       clock, rising edge
//   PRESET     synchronous active-high reset (also clears the memory)
//   PSEL       completer select
//   PENABLE    access-phase indicator
//   PWRITE     1 = write, 0 = read
//   PADDR      byte address (ADDR_WIDTH)
//   PWDATA     write data (DATA_WIDTH, must be 32)
//   PSTRB      byte strobes, only when APB_SLAVE_PSTRB_EN is defined
//   PREADY     registered completion
//   PRDATA     registered read data, valid while PREADY=1 on a read
//   PSLVERR    registered error response, valid while PREADY=1
//   xfer_done  one-cycle pulse after a completed transfer
//
// Optional feature macro: APB_SLAVE_PSTRB_EN
//   Adds PSTRB. Writes update only strobed byte lanes; a write with
//   PSTRB=0 completes without error and changes nothing; a read with
//   PSTRB!=0 completes with PSLVERR=1.

module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic                    xfer_done
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wcnt;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
`ifdef APB_SLAVE_PSTRB_EN
    logic [NB-1:0]           strb_q;
    logic [NB-1:0]           rsp_strb;
`endif

    // Response source: live bus at the setup edge (needed when
    // WAIT_CYCLES==0), latched copy once in ACCESS.
    logic [ADDR_WIDTH-1:0]   rsp_addr;
    logic                    rsp_write;
    logic [ADDR_WIDTH-1:0]   rsp_word;
    logic [IDX_W-1:0]        rsp_idx;
    logic                    rsp_err;
    logic [DATA_WIDTH-1:0]   rsp_data;

    always_comb begin
        rsp_addr  = addr_q;
        rsp_write = write_q;
`ifdef APB_SLAVE_PSTRB_EN
        rsp_strb  = strb_q;
`endif
        if (state == IDLE) begin
            rsp_addr  = PADDR;
            rsp_write = PWRITE;
`ifdef APB_SLAVE_PSTRB_EN
            rsp_strb  = PSTRB;
`endif
        end
        rsp_word = rsp_addr >> 2;
        rsp_idx  = rsp_word[IDX_W-1:0];
        rsp_err  = (rsp_addr[1:0] != 2'b00) ||
                   (rsp_word >= ADDR_WIDTH'(MEM_DEPTH));
`ifdef APB_SLAVE_PSTRB_EN
        if (!rsp_write && (rsp_strb != '0))
            rsp_err = 1'b1;
`endif
        rsp_data = '0;
        if (!rsp_write && !rsp_err)
            rsp_data = mem[rsp_idx];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
            xfer_done <= 1'b0;
            wcnt      <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
`ifdef APB_SLAVE_PSTRB_EN
            strb_q    <= '0;
`endif
            for (int unsigned i = 0; i < MEM_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    PREADY  <= 1'b0;
                    PRDATA  <= '0;
                    PSLVERR <= 1'b0;
                    // PENABLE without a preceding setup phase is ignored.
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
                        strb_q  <= PSTRB;
`endif
                        wcnt    <= 4'(WAIT_CYCLES);
                        state   <= ACCESS;
                        if (WAIT_CYCLES == 0) begin
                            PREADY  <= 1'b1;
                            PRDATA  <= rsp_data;
                            PSLVERR <= rsp_err;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        // Master abort: drop the transfer silently.
                        PREADY  <= 1'b0;
                        PRDATA  <= '0;
                        PSLVERR <= 1'b0;
                        state   <= IDLE;
                    end else if (PENABLE && PREADY) begin
                        if (write_q && !PSLVERR) begin
`ifdef APB_SLAVE_PSTRB_EN
                            for (int unsigned b = 0; b < NB; b++)
                                if (strb_q[b])
                                    mem[addr_q[IDX_W+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
`else
                            mem[addr_q[IDX_W+1:2]] <= wdata_q;
`endif
                        end
                        PREADY    <= 1'b0;
                        PRDATA    <= '0;
                        PSLVERR   <= 1'b0;
                        xfer_done <= 1'b1;
                        state     <= IDLE;
                    end else if (PENABLE) begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            PREADY  <= 1'b1;
                            PRDATA  <= rsp_data;
                            PSLVERR <= rsp_err;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
